mem_bus_scheduler: RTL and testbench

Two-requester scheduler that shares the single unified RAM port between the CPU instruction-fetch and data-access interfaces. It sits between the CPU and the RAM wrapper. It grants one transaction at a time with data-priority arbitration and an anti-starvation counter for fetches, forwards the RAM ready and read data back to the granted requester, and aborts any transaction that exceeds a timeout, reporting it on an error pulse.

---
 rtl/mem_bus_scheduler.sv | 122 ++++++++++++
 tb/tb_mem_bus_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_scheduler.sv
// Shares one unified RAM port between instruction fetch and data access.
// Data wins arbitration unless fetches have been starved; stalled grants time out.
module mem_bus_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_mem_rd_i,
  input  logic [31:0] instr_mem_addr_i,
  output logic        instr_mem_ready_o,
  output logic [31:0] instr_mem_data_o,
  input  logic        data_mem_rd_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [31:0] data_mem_data_i,
  input  logic [3:0]  byte_select_i,
  output logic        data_mem_ready_o,
  output logic [31:0] data_mem_data_o,
  output logic        merged_mem_rd_o,
  output logic        merged_mem_wr_o,
  output logic [31:0] merged_mem_addr_o,
  output logic [31:0] merged_mem_data_o,
  output logic [3:0]  merged_byte_select_o,
  input  logic        merged_mem_ready_i,
  input  logic [31:0] merged_mem_data_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] starve_cnt;
  logic [7:0] to_cnt;
  logic       data_pend;
  logic       timeout_hit;
  logic       grant_done;

  assign data_pend   = data_mem_rd_i | data_mem_wr_i;
  // Real ready takes precedence over a timeout landing in the same cycle.
  assign timeout_hit = (state_q != IDLE) && !merged_mem_ready_i && (to_cnt == TO_LAST);
  assign grant_done  = (state_q != IDLE) && (merged_mem_ready_i || timeout_hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (instr_mem_rd_i && data_pend)
          state_d = (starve_cnt >= STARVE_LIM) ? GNT_I : GNT_D;
        else if (instr_mem_rd_i)
          state_d = GNT_I;
        else if (data_pend)
          state_d = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (grant_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
      to_cnt     <= '0;
    end else if (state_q == IDLE) begin
      to_cnt <= '0;
      if (state_d == GNT_I)
        starve_cnt <= '0;
      else if (state_d == GNT_D && instr_mem_rd_i && starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;
    end else begin
      to_cnt <= grant_done ? 8'd0 : to_cnt + 8'd1;
    end
  end

  // Outputs are forced quiet during reset so a reset mid-grant never leaks a ready.
  always_comb begin
    instr_mem_ready_o    = 1'b0;
    instr_mem_data_o     = '0;
    data_mem_ready_o     = 1'b0;
    data_mem_data_o      = '0;
    merged_mem_rd_o      = 1'b0;
    merged_mem_wr_o      = 1'b0;
    merged_mem_addr_o    = '0;
    merged_mem_data_o    = '0;
    merged_byte_select_o = '0;
    err_o                = 1'b0;
    if (!rst_i) begin
      case (state_q)
        GNT_I: begin
          merged_mem_rd_o   = 1'b1;
          merged_mem_addr_o = instr_mem_addr_i;
          instr_mem_ready_o = merged_mem_ready_i | timeout_hit;
          instr_mem_data_o  = merged_mem_ready_i ? merged_mem_data_i : 32'h0;
          err_o             = timeout_hit;
        end
        GNT_D: begin
          merged_mem_wr_o      = data_mem_wr_i;
          merged_mem_rd_o      = data_mem_rd_i & ~data_mem_wr_i;
          merged_mem_addr_o    = data_mem_addr_i;
          merged_mem_data_o    = data_mem_data_i;
          merged_byte_select_o = byte_select_i;
          data_mem_ready_o     = merged_mem_ready_i | timeout_hit;
          data_mem_data_o      = merged_mem_ready_i ? merged_mem_data_i : 32'h0;
          err_o                = timeout_hit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed bench for mem_bus_scheduler: arbitration, starvation, writes,
// timeout and reset mid-grant, with hand-computed expectations.
module tb_mem_bus_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_rd;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic        data_rd;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  bsel;
  logic        data_ready;
  logic [31:0] data_data;
  logic        m_rd;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_bsel;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [136:0] all_out;
  assign all_out = {instr_ready, instr_data, data_ready, data_data, m_rd, m_wr,
                    m_addr, m_wdata, m_bsel, err};

  mem_bus_scheduler #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_mem_rd_i(instr_rd), .instr_mem_addr_i(instr_addr),
    .instr_mem_ready_o(instr_ready), .instr_mem_data_o(instr_data),
    .data_mem_rd_i(data_rd), .data_mem_wr_i(data_wr),
    .data_mem_addr_i(data_addr), .data_mem_data_i(data_wdata),
    .byte_select_i(bsel),
    .data_mem_ready_o(data_ready), .data_mem_data_o(data_data),
    .merged_mem_rd_o(m_rd), .merged_mem_wr_o(m_wr),
    .merged_mem_addr_o(m_addr), .merged_mem_data_o(m_wdata),
    .merged_byte_select_o(m_bsel),
    .merged_mem_ready_i(m_ready), .merged_mem_data_i(m_rdata),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [136:0] obs, input logic [136:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called with the grant already taken at the coming negedge; memory answers in one cycle.
  task automatic serve(input bit exp_instr, input logic [31:0] rdata, input string tag,
                       input bit drop_i, input bit drop_d);
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = rdata;
    #2;
    chk({tag, " addr"}, m_addr, exp_instr ? instr_addr : data_addr);
    chk({tag, " rdy"}, {instr_ready, data_ready}, exp_instr ? 2'b10 : 2'b01);
    chk({tag, " data"}, exp_instr ? instr_data : data_data, rdata);
    @(negedge clk);
    m_ready = 1'b0;
    if (drop_i) instr_rd = 1'b0;
    if (drop_d) begin
      data_rd = 1'b0;
      data_wr = 1'b0;
    end
    #2;
    chk({tag, " idle"}, {instr_ready, data_ready, m_rd, m_wr}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; instr_rd = 1'b0; instr_addr = '0; data_rd = 1'b0; data_wr = 1'b0;
    data_addr = '0; data_wdata = '0; bsel = '0; m_ready = 1'b0; m_rdata = '0;
    repeat (3) @(negedge clk);
    #2 chk("reset outputs", all_out, '0);
    @(negedge clk);
    rst = 1'b0;
    #2 chk("post reset outputs", all_out, '0);

    // Lone fetch, memory ready in the second grant cycle
    @(negedge clk);
    instr_rd = 1'b1; instr_addr = 32'h100;
    #2 chk("fetch latency", m_rd, 1'b0);
    @(negedge clk);
    #2 chk("fetch cyc1 bus", {m_rd, m_wr, m_addr, m_bsel}, {1'b1, 1'b0, 32'h100, 4'b0000});
    chk("fetch cyc1 rdy", {instr_ready, data_ready}, 2'b00);
    @(negedge clk);
    m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
    #2 chk("fetch done", {instr_ready, instr_data}, {1'b1, 32'hDEADBEEF});
    chk("fetch data port quiet", {data_ready, data_data, m_rd}, {1'b0, 32'h0, 1'b1});
    @(negedge clk);
    instr_rd = 1'b0;
    #2 chk("ready in idle ignored", {instr_ready, data_ready, m_rd, err}, 4'b0000);
    @(negedge clk);
    m_ready = 1'b0;

    // Simultaneous fetch and data read: data first, then fetch
    instr_rd = 1'b1; instr_addr = 32'h104; data_rd = 1'b1; data_addr = 32'h20;
    serve(1'b0, 32'h11111111, "both first", 1'b0, 1'b1);
    serve(1'b1, 32'h22222222, "both second", 1'b1, 1'b0);

    // Starvation: four data grants then one fetch, twice
    instr_rd = 1'b1; instr_addr = 32'h300; data_rd = 1'b1; data_addr = 32'h30;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        serve(1'b0, 32'h1000 + 32'(k), $sformatf("starve r%0d d%0d", r, k), 1'b0, 1'b0);
      serve(1'b1, 32'h2000 + 32'(r), $sformatf("starve r%0d fetch", r), r == 1, r == 1);
    end

    // Write, then rd+wr together behaving as a write
    data_wr = 1'b1; data_addr = 32'h40; data_wdata = 32'h12345678; bsel = 4'b0011;
    @(negedge clk);
    #2 chk("write bus", {m_rd, m_wr, m_bsel, m_wdata, m_addr},
           {1'b0, 1'b1, 4'b0011, 32'h12345678, 32'h40});
    m_ready = 1'b1; m_rdata = 32'h0;
    #1 chk("write rdy", {data_ready, instr_ready}, 2'b10);
    @(negedge clk);
    m_ready = 1'b0;
    data_rd = 1'b1;
    @(negedge clk);
    #2 chk("rdwr bus", {m_rd, m_wr, m_bsel, m_wdata, m_addr},
           {1'b0, 1'b1, 4'b0011, 32'h12345678, 32'h40});
    @(negedge clk);
    m_ready = 1'b1; m_rdata = 32'h0BADF00D;
    #2 chk("rdwr rdy", {data_ready, data_data}, {1'b1, 32'h0BADF00D});
    @(negedge clk);
    m_ready = 1'b0; data_rd = 1'b0; data_wr = 1'b0; bsel = 4'b0000;

    // Timeout: memory never answers
    m_rdata = 32'hFFFFFFFF;
    data_rd = 1'b1; data_addr = 32'h80;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #2 chk($sformatf("timeout wait %0d", k), {data_ready, err, m_rd}, 3'b001);
    end
    @(negedge clk);
    #2 chk("timeout fire", {data_ready, data_data, err}, {1'b1, 32'h0, 1'b1});
    data_rd = 1'b0;
    @(negedge clk);
    #2 chk("timeout after", {err, data_ready, m_rd}, 3'b000);
    data_rd = 1'b1; data_addr = 32'h84;
    serve(1'b0, 32'hA5A5A5A5, "after timeout", 1'b0, 1'b1);

    // Reset in the second cycle of a fetch grant
    instr_rd = 1'b1; instr_addr = 32'h200;
    @(negedge clk);
    #2 chk("rst grant cyc1", {m_rd, m_addr}, {1'b1, 32'h200});
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b1; m_rdata = 32'h55;
    #2 chk("rst no ready", {instr_ready, data_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0; m_ready = 1'b0; instr_rd = 1'b0;
    #2 chk("rst following outputs", all_out, '0);
    @(negedge clk);
    instr_rd = 1'b1; instr_addr = 32'h204;
    #2 chk("rst state idle", m_rd, 1'b0);
    serve(1'b1, 32'h77, "post rst fetch", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
